ring_osc_meter: RTL and testbench

Controller and frequency meter for the chip's free-running ring oscillators.
- On a start command, enables one selected ring and waits a settle window.
- Then counts that ring's rising edges over a programmable gate of clk cycles and reports the count.
- Sits between the top-level IO wrapper (command/readout) and the ring_osc instances, which are powered only while being measured.

---
 rtl/ring_osc_pkg.sv | 24 ++
 rtl/ring_osc_edge_sync.sv | 34 +++
 rtl/ring_osc_meter.sv | 148 ++++++++++++++
 tb/tb_ring_osc_meter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_osc_pkg.sv
// ============================================================================
// ring_osc_pkg : shared FSM encoding and default widths for ring_osc_meter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package ring_osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int c_DEF_NUM_OSC       = 4;
  localparam int c_DEF_SEL_W         = 2;
  localparam int c_DEF_GATE_W        = 16;
  localparam int c_DEF_COUNT_W       = 16;
  localparam int c_DEF_SETTLE_CYCLES = 8;

endpackage

`default_nettype wire

// File: rtl/ring_osc_edge_sync.sv
// ============================================================================
// ring_osc_edge_sync : 2-flop synchronizer, delay flop and rising-edge pulse
// Revision           : 1.0
// ============================================================================
`default_nettype none

module ring_osc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~s3_q;

endmodule

`default_nettype wire

// File: rtl/ring_osc_meter.sv
// ============================================================================
// ring_osc_meter : enables one ring oscillator, settles, then counts its
//                  rising edges over a programmable gate of clk cycles
// Revision       : 1.0
// ============================================================================
`default_nettype none

module ring_osc_meter
  import ring_osc_pkg::*;
#(
  parameter int NUM_OSC       = c_DEF_NUM_OSC,
  parameter int SEL_W         = c_DEF_SEL_W,
  parameter int GATE_W        = c_DEF_GATE_W,
  parameter int COUNT_W       = c_DEF_COUNT_W,
  parameter int SETTLE_CYCLES = c_DEF_SETTLE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SEL_W-1:0]   sel,
  input  logic [GATE_W-1:0]  gate_cycles,
  input  logic [NUM_OSC-1:0] osc_in,
  output logic [NUM_OSC-1:0] osc_en,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] count,
  output logic               overflow,
  output logic               sel_err
);

  localparam int                 c_SETTLE_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W:0]     c_NUM_OSC_X   = (SEL_W + 1)'(NUM_OSC);
  localparam logic [COUNT_W-1:0] c_COUNT_MAX   = '1;

  state_t                  state_q;
  logic [SEL_W-1:0]        sel_q;
  logic                    sel_err_q;
  logic [GATE_W-1:0]       gate_len_q;
  logic [GATE_W-1:0]       gate_cnt_q;
  logic [c_SETTLE_W-1:0]   settle_cnt_q;
  logic [COUNT_W-1:0]      count_q;
  logic                    overflow_q;
  logic                    done_q;
  logic [NUM_OSC-1:0]      osc_en_q;

  logic                    w_sel_bad;
  logic                    w_ring;
  logic                    w_rise;

  assign w_sel_bad = ({1'b0, sel} >= c_NUM_OSC_X);

  // An invalid selection feeds a constant 0 so no edges can be counted.
  always_comb begin
    w_ring = 1'b0;
    for (int i = 0; i < NUM_OSC; i++) begin
      if (!sel_err_q && (sel_q == SEL_W'(i))) begin
        w_ring = osc_in[i];
      end
    end
  end

  ring_osc_edge_sync u_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (w_ring),
    .rise_o  (w_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      sel_err_q    <= 1'b0;
      gate_len_q   <= '0;
      gate_cnt_q   <= '0;
      settle_cnt_q <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      done_q       <= 1'b0;
      osc_en_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sel_q        <= sel;
            gate_len_q   <= gate_cycles;
            sel_err_q    <= w_sel_bad;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            settle_cnt_q <= '0;
            osc_en_q     <= w_sel_bad ? '0 : (NUM_OSC'(1) << sel);
            state_q      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == c_SETTLE_LAST) begin
            settle_cnt_q <= '0;
            if (gate_len_q == '0) begin
              state_q  <= ST_DONE;
              done_q   <= 1'b1;
              osc_en_q <= '0;
            end else begin
              state_q    <= ST_GATE;
              gate_cnt_q <= gate_len_q;
            end
          end else begin
            settle_cnt_q <= settle_cnt_q + c_SETTLE_W'(1);
          end
        end
        ST_GATE: begin
          if (w_rise) begin
            if (count_q == c_COUNT_MAX) begin
              overflow_q <= 1'b1;
            end else begin
              count_q <= count_q + COUNT_W'(1);
            end
          end
          if (gate_cnt_q == GATE_W'(1)) begin
            gate_cnt_q <= '0;
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            osc_en_q   <= '0;
          end else begin
            gate_cnt_q <= gate_cnt_q - GATE_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign osc_en   = osc_en_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign sel_err  = sel_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ring_osc_meter.sv
// ============================================================================
// tb_ring_osc_meter : scoreboard bench for ring_osc_meter with gated rings
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_ring_osc_meter;

  localparam int NUM_OSC = 3;
  localparam int SEL_W   = 2;
  localparam int GATE_W  = 16;
  localparam int COUNT_W = 4;
  localparam int SETTLE  = 8;
  localparam int CNT_MAX = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [SEL_W-1:0]   sel;
  logic [GATE_W-1:0]  gate_cycles;
  logic [NUM_OSC-1:0] osc_in;
  logic [NUM_OSC-1:0] osc_en;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] count;
  logic               overflow;
  logic               sel_err;

  ring_osc_meter #(
    .NUM_OSC       (NUM_OSC),
    .SEL_W         (SEL_W),
    .GATE_W        (GATE_W),
    .COUNT_W       (COUNT_W),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .sel         (sel),
    .gate_cycles (gate_cycles),
    .osc_in      (osc_in),
    .osc_en      (osc_en),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .overflow    (overflow),
    .sel_err     (sel_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ring model: a ring only oscillates while its enable is high, starting low.
  int period [NUM_OSC];
  int ph     [NUM_OSC];

  always @(negedge clk) begin
    for (int i = 0; i < NUM_OSC; i++) begin
      if (osc_en[i] === 1'b1) begin
        osc_in[i] <= ((ph[i] % period[i]) >= (period[i] / 2));
        ph[i]     <= ph[i] + 1;
      end else begin
        osc_in[i] <= 1'b0;
        ph[i]     <= 0;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                 e0;
    int                 lat;
    logic [NUM_OSC-1:0] en;
    logic [COUNT_W-1:0] cnt;
    logic               ovf;
    logic               err;
  } exp_t;

  exp_t sbq[$];

  // Monitor: cycle k after E0 is the interval following the accepting edge.
  always @(negedge clk) begin
    int k;
    if (rst === 1'b0) begin
      if (sbq.size() > 0) begin
        k = cyc - sbq[0].e0 + 1;
        if (k == 1) begin
          check_val("cleared_count", 32'(count), 32'(0));
          check_val("cleared_ovf", 32'(overflow), 32'(0));
          check_val("sel_err_latched", 32'(sel_err), 32'(sbq[0].err));
        end
        if (k < sbq[0].lat) begin
          check_val("osc_en_active", 32'(osc_en), 32'(sbq[0].en));
          check_val("busy_active", 32'(busy), 32'(1));
          check_val("no_early_done", 32'(done), 32'(0));
        end
        if (done === 1'b1) begin
          check_val("done_latency", 32'(k), 32'(sbq[0].lat));
          check_val("count", 32'(count), 32'(sbq[0].cnt));
          check_val("overflow", 32'(overflow), 32'(sbq[0].ovf));
          check_val("sel_err", 32'(sel_err), 32'(sbq[0].err));
          check_val("osc_en_done", 32'(osc_en), 32'(0));
          check_val("busy_done", 32'(busy), 32'(1));
          void'(sbq.pop_front());
        end
      end else if (done === 1'b1) begin
        check_val("unexpected_done", 32'(done), 32'(0));
      end
    end
  end

  task automatic do_start(input int s, input int g);
    exp_t e;
    int   edges;
    @(negedge clk);
    start       = 1'b1;
    sel         = SEL_W'(s);
    gate_cycles = GATE_W'(g);
    @(posedge clk);
    #1;
    start = 1'b0;
    e.e0  = cyc;
    e.lat = (g == 0) ? SETTLE + 1 : SETTLE + g + 1;
    e.err = (s >= NUM_OSC);
    edges = 0;
    if (!e.err) begin
      e.en  = NUM_OSC'(1) << s;
      edges = g / period[s];
    end else begin
      e.en = '0;
    end
    e.cnt = COUNT_W'((edges > CNT_MAX) ? CNT_MAX : edges);
    e.ovf = (edges > CNT_MAX);
    sbq.push_back(e);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sbq.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() > 0) begin
      check_val(tag, 32'(sbq.size()), 32'(0));
      sbq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_osc_en"}, 32'(osc_en), 32'(0));
    check_val({tag, "_busy"}, 32'(busy), 32'(0));
    check_val({tag, "_done"}, 32'(done), 32'(0));
    check_val({tag, "_count"}, 32'(count), 32'(0));
    check_val({tag, "_ovf"}, 32'(overflow), 32'(0));
    check_val({tag, "_sel_err"}, 32'(sel_err), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < NUM_OSC; i++) begin
      period[i] = 8;
      ph[i]     = 0;
    end
    osc_in      = '0;
    rst         = 1'b1;
    start       = 1'b1;
    sel         = 2'd2;
    gate_cycles = 16'd64;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    start = 1'b0;
    rst   = 1'b0;
    repeat (2) @(negedge clk);

    // Basic measurement, then result held in IDLE.
    do_start(2, 64);
    wait_drain("timeout_basic");
    check_val("held_count", 32'(count), 32'(8));
    check_val("idle_busy", 32'(busy), 32'(0));

    // Zero-length gate.
    do_start(1, 0);
    wait_drain("timeout_zero_gate");

    // Saturation with a faster ring.
    period[2] = 4;
    do_start(2, 200);
    wait_drain("timeout_saturate");
    check_val("held_ovf", 32'(overflow), 32'(1));
    period[2] = 8;

    // Start pulses during GATE must be ignored.
    do_start(2, 64);
    repeat (20) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      start = 1'b1;
      sel   = SEL_W'(j);
      gate_cycles = 16'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
    end
    wait_drain("timeout_ignored");
    repeat (20) @(negedge clk);
    check_val("no_restart_busy", 32'(busy), 32'(0));

    // Out-of-range select.
    do_start(3, 16);
    wait_drain("timeout_sel_err");

    // Reset in the middle of the gate, then a fresh measurement.
    do_start(2, 64);
    repeat (30) @(negedge clk);
    sbq.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    repeat (2) @(negedge clk);
    do_start(2, 64);
    wait_drain("timeout_after_reset");
    check_val("after_reset_count", 32'(count), 32'(8));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
